// File: rtl/dsp_ret1_pkg.sv
// Shared constants and helpers for the return-to-one clock divider.
// Holds the default divide ratio, the start-up delay limit and the default low-phase length.
package dsp_ret1_pkg;

    localparam int DIV_DEFAULT   = 4;
    localparam int START_DLY_MAX = 255;

    // Odd ratios round the low phase down, so the high phase is the longer one.
    function automatic int low_cyc_default(input int div);
        return div / 2;
    endfunction

endpackage

// File: rtl/dsp_ret1_clk_top_phase_cnt.sv
// Phase counter for the return-to-one divider: wraps at DIV-1 and flags the low phase.
// phase_low describes the phase the counter is about to enter, so the clkout flop stays aligned with it.
module ret1_phase_cnt
    import dsp_ret1_pkg::*;
#(
    parameter int DIV     = DIV_DEFAULT,
    parameter int LOW_CYC = low_cyc_default(DIV),
    parameter int CNT_W   = $clog2(DIV)
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic phase_low
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DIV - 1)) begin
            cnt_d = '0;
        end
    end

    assign phase_low = (cnt_d < CNT_W'(LOW_CYC));

    // Reset parks the counter on its last phase, so the first run edge lands on phase 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= CNT_W'(DIV - 1);
        end else if (run) begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dsp_ret1_clk_top.sv
// Return-to-one clock divider: clkout idles high through reset and the start-up hold,
// then runs LOW_CYC cycles low and DIV-LOW_CYC cycles high per period.
module dsp_ret1_clk_top
    import dsp_ret1_pkg::*;
#(
    parameter int DIV       = DIV_DEFAULT,
    parameter int LOW_CYC   = low_cyc_default(DIV),
    parameter int START_DLY = 0,
    parameter int CNT_W     = $clog2(DIV)
) (
    input  logic clk,
    input  logic rst,
    output logic clkout
);

    localparam int DLY_W = 8;

    if (DIV < 2) begin : g_bad_div
        $error("dsp_ret1_clk_top: DIV must be >= 2");
    end
    if (LOW_CYC < 1 || LOW_CYC > DIV - 1) begin : g_bad_low
        $error("dsp_ret1_clk_top: LOW_CYC must lie in 1..DIV-1");
    end
    if (START_DLY < 0 || START_DLY > START_DLY_MAX) begin : g_bad_dly
        $error("dsp_ret1_clk_top: START_DLY must lie in 0..255");
    end

    logic [DLY_W-1:0] dly_q;
    logic [DLY_W-1:0] dly_d;
    logic             clkout_q;
    logic             clkout_d;
    logic             run;
    logic             phaseLow;

    assign run = (dly_q == '0);

    ret1_phase_cnt #(
        .DIV     (DIV),
        .LOW_CYC (LOW_CYC),
        .CNT_W   (CNT_W)
    ) u_phase_cnt (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .phase_low (phaseLow)
    );

    always_comb begin
        dly_d    = dly_q;
        clkout_d = clkout_q;
        if (!run) begin
            dly_d = dly_q - DLY_W'(1);
        end else begin
            clkout_d = ~phaseLow;
        end
    end

    // Async reset drives clkout high immediately; the port is taken straight from this flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_q    <= DLY_W'(START_DLY);
            clkout_q <= 1'b1;
        end else begin
            dly_q    <= dly_d;
            clkout_q <= clkout_d;
        end
    end

    assign clkout = clkout_q;

endmodule

// File: tb/tb_dsp_ret1_clk_top.sv
// Directed bench for dsp_ret1_clk_top: four parameterisations share one clock and reset
// and are compared edge by edge against hand-derived return-to-one patterns.
module tb_dsp_ret1_clk_top;

    logic clk = 1'b0;
    logic rst;
    logic co4, co5, co2, coD;

    int total = 0;
    int bad   = 0;
    int rise5 = 0;
    int tog4  = 0;
    logic countTog = 1'b0;

    always #5 clk = ~clk;

    dsp_ret1_clk_top #(.DIV(4)) dut4 (.clk(clk), .rst(rst), .clkout(co4));
    dsp_ret1_clk_top #(.DIV(5)) dut5 (.clk(clk), .rst(rst), .clkout(co5));
    dsp_ret1_clk_top #(.DIV(2)) dut2 (.clk(clk), .rst(rst), .clkout(co2));
    dsp_ret1_clk_top #(.DIV(4), .START_DLY(3)) dutD (.clk(clk), .rst(rst), .clkout(coD));

    always @(posedge co5) if (!rst) rise5++;
    always @(co4) if (countTog) tog4++;

    // Expected clkout after the k-th edge since reset release (k from 0).
    function automatic logic expPat(input int k, input int div, input int low, input int dly);
        if (k < dly) return 1'b1;
        return ((k - dly) % div) >= low;
    endfunction

    task automatic checkOutput(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkAll(input int k);
        checkOutput($sformatf("div4 k=%0d", k), int'(co4), int'(expPat(k, 4, 2, 0)));
        checkOutput($sformatf("div5 k=%0d", k), int'(co5), int'(expPat(k, 5, 2, 0)));
        checkOutput($sformatf("div2 k=%0d", k), int'(co2), int'(expPat(k, 2, 1, 0)));
        checkOutput($sformatf("dly3 k=%0d", k), int'(coD), int'(expPat(k, 4, 2, 3)));
    endtask

    initial begin
        rst = 1'b1;
        // Reset held for the first 100 ns: every output idles high.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("reset div4", int'(co4), 1);
            checkOutput("reset div5", int'(co5), 1);
            checkOutput("reset div2", int'(co2), 1);
            checkOutput("reset dly3", int'(coD), 1);
        end
        rst   = 1'b0;
        rise5 = 0;

        for (int k = 0; k < 20; k++) begin
            applyStimulus();
            checkAll(k);
        end
        checkOutput("div5 rises in 20 edges", rise5, 4);

        applyStimulus();
        checkOutput("div4 low before mid reset", int'(co4), 0);
        rst = 1'b1;
        #1;
        checkOutput("mid reset div4 async", int'(co4), 1);
        checkOutput("mid reset div2 async", int'(co2), 1);
        checkOutput("mid reset dly3 async", int'(coD), 1);
        @(negedge clk);
        checkOutput("mid reset div4 held", int'(co4), 1);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus();
            checkAll(k);
        end

        rst = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        tog4     = 0;
        countTog = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            applyStimulus();
            checkOutput($sformatf("long div4 k=%0d", k), int'(co4), int'(expPat(k, 4, 2, 0)));
        end
        countTog = 1'b0;
        checkOutput("long div4 transitions", tog4, 500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
